// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_bit.sv
// One-bit full subtractor cell.
// Purely combinational; time-shared by the controller.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // difference and borrow of a - b - bin
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller.
// One fs_bit cell stepped LSB-first over WIDTH cycles.
import serial_sub_pkg::*;

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] d_msb;
  logic [CW-1:0]    count;
  logic             bf;
  logic             d;
  logic             bo;

  fs_bit u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bf),
    .d    (d),
    .bout (bo)
  );

  // place the new difference bit at the result MSB
  always_comb begin
    d_msb = '0;
    d_msb[WIDTH-1] = d;
  end

  assign diff = res;

  // handshake FSM and serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      count      <= '0;
      bf         <= 1'b0;
      borrow_out <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            bf       <= borrow_in;
            count    <= '0;
            state    <= S_SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          bf    <= bo;
          res   <= (res >> 1) | d_msb;
          count <= count + CW'(1);
          if (count == LAST) begin
            state      <= S_DONE;
            borrow_out <= bo;
            out_valid  <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // handshake controls must never be unknown
  a_in_valid_known: assert property (
    @(posedge clk) disable iff (!rst_n) !$isunknown(in_valid));
  a_out_ready_known: assert property (
    @(posedge clk) disable iff (!rst_n) !$isunknown(out_ready));

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1).
// Random operands checked against an arithmetic model.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       iv8 = 1'b0, ir8, bi8 = 1'b0;
  logic       ov8, or8 = 1'b0, bo8, busy8;
  logic [7:0] a8 = '0, b8 = '0, d8;

  logic       iv1 = 1'b0, ir1, bi1 = 1'b0;
  logic       ov1, or1 = 1'b0, bo1, busy1;
  logic [0:0] a1 = '0, b1 = '0, d1;

  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .borrow_in(bi8),
    .out_valid(ov8), .out_ready(or8),
    .diff(d8), .borrow_out(bo8), .busy(busy8)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .borrow_in(bi1),
    .out_valid(ov1), .out_ready(or1),
    .diff(d1), .borrow_out(bo1), .busy(busy1)
  );

  // {borrow, diff} = a - b - bin, by plain integer arithmetic
  function automatic logic [8:0] ref8(int a, int b, int bin);
    int r;
    r = a - b - bin;
    return {r < 0, r[7:0]};
  endfunction

  function automatic logic [1:0] ref1(int a, int b, int bin);
    int r;
    r = a - b - bin;
    return {r < 0, r[0]};
  endfunction

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input bit churn,
                        output logic [7:0] d, output logic bo,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    a8 = a; b8 = b; bi8 = bin; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (churn) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        bi8 = 1'($urandom); iv8 = 1'($urandom);
      end
      @(posedge clk); #1;
      if (ov8) begin
        lat = i;
        break;
      end
    end
    iv8 = 1'b0;
    d = d8; bo = bo8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic do_op1(input logic a, input logic b, input logic bin,
                        output logic d, output logic bo, output int lat);
    @(negedge clk);
    a1 = a; b1 = b; bi1 = bin; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ov1) begin
        lat = i;
        break;
      end
    end
    d = d1; bo = bo1;
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp++; if (ir8 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", ir8); end
    cmp++; if (ov8 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", ov8); end
    cmp++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy8); end
    cmp++; if (d8 !== 8'h00) begin bad++; $display("FAIL rst_diff got %h want 00", d8); end
    cmp++; if (bo8 !== 1'b0) begin bad++; $display("FAIL rst_borrow got %b want 0", bo8); end
    cmp++; if ({ir1, ov1, busy1} !== 3'b100) begin
      bad++; $display("FAIL rst_w1 got %b want 100", {ir1, ov1, busy1});
    end
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo; int lat;
    do_op8(8'd5, 8'd3, 1'b0, 1'b0, d, bo, lat);
    cmp++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got %0d want 8", lat); end
    cmp++; if (d !== 8'h02) begin bad++; $display("FAIL basic_diff got %h want 02", d); end
    cmp++; if (bo !== 1'b0) begin bad++; $display("FAIL basic_borrow got %b want 0", bo); end
  endtask

  task automatic test_borrow();
    logic [7:0] d; logic bo; int lat;
    do_op8(8'h00, 8'h01, 1'b0, 1'b0, d, bo, lat);
    cmp++; if ({bo, d} !== ref8(0, 1, 0)) begin
      bad++; $display("FAIL borrow_0m1 got %b/%h want 1/ff", bo, d);
    end
    do_op8(8'hFF, 8'hFF, 1'b1, 1'b0, d, bo, lat);
    cmp++; if ({bo, d} !== 9'h1FF) begin
      bad++; $display("FAIL borrow_ffmff1 got %b/%h want 1/ff", bo, d);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int n;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h11; bi8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    held = d8;
    cmp++; if ({bo8, held} !== ref8(8'h40, 8'h11, 0)) begin
      bad++; $display("FAIL bp_result got %b/%h want 0/2f", bo8, held);
    end
    a8 = 8'hFF; b8 = 8'h00; iv8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp++; if (ov8 !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got %b want 1", ov8); end
      cmp++; if (d8 !== held) begin bad++; $display("FAIL bp_hold_diff got %h want %h", d8, held); end
      cmp++; if (ir8 !== 1'b0) begin bad++; $display("FAIL bp_in_ready got %b want 0", ir8); end
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0; iv8 = 1'b0;
    cmp++; if ({ir8, ov8, busy8} !== 3'b100) begin
      bad++; $display("FAIL bp_release got %b want 100", {ir8, ov8, busy8});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic bo; int lat; int seen;
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; bi8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    cmp++; if (busy8 !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy8); end
    rst_n = 1'b0;
    #1;
    cmp++; if ({ir8, ov8, busy8, bo8, d8} !== {4'b1000, 8'h00}) begin
      bad++; $display("FAIL mid_reset got %b want 100000000000", {ir8, ov8, busy8, bo8, d8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    cmp++; if (seen !== 0) begin bad++; $display("FAIL mid_no_valid got %0d want 0", seen); end
    do_op8(8'd9, 8'd4, 1'b0, 1'b0, d, bo, lat);
    cmp++; if ({bo, d} !== 9'h005) begin
      bad++; $display("FAIL mid_after got %b/%h want 0/05", bo, d);
    end
  endtask

  task automatic test_churn();
    logic [7:0] a, b, d; logic bin, bo; int lat;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      do_op8(a, b, bin, 1'b1, d, bo, lat);
      cmp++; if ({bo, d} !== ref8(a, b, bin) || lat !== 8) begin
        bad++; $display("FAIL churn a=%h b=%h bin=%b got %b/%h lat %0d want %h lat 8",
                        a, b, bin, bo, d, lat, ref8(a, b, bin));
      end
    end
  endtask

  task automatic test_w1();
    logic d, bo; int lat;
    for (int k = 0; k < 8; k++) begin
      do_op1(k[2], k[1], k[0], d, bo, lat);
      cmp++; if ({bo, d} !== ref1(k[2], k[1], k[0]) || lat !== 1) begin
        bad++; $display("FAIL w1 k=%0d got %b%b lat %0d want %b lat 1",
                        k, bo, d, lat, ref1(k[2], k[1], k[0]));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, d; logic bin, bo; int lat;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      do_op8(a, b, bin, 1'b0, d, bo, lat);
      cmp++; if ({bo, d} !== ref8(a, b, bin) || lat !== 8) begin
        bad++; $display("FAIL random a=%h b=%h bin=%b got %b/%h lat %0d want %h lat 8",
                        a, b, bin, bo, d, lat, ref8(a, b, bin));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_reset_mid();
    test_churn();
    test_w1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
